// File: rtl/pc_fetch.sv
// PC register and single-outstanding instruction fetch sequencer (IDLE/REQ/WAIT/HOLD[/FAULT]).
// Optional PC_MISALIGN_CHK_EN: misaligned retire target parks the fetcher in FAULT until reset.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] fetch_cnt,
  output logic        misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef PC_MISALIGN_CHK_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD} state_t;
`endif

  state_t state;
  logic   misalign_q;

  // Low pc bits are kept for the core but never reach the memory port.
  assign imem_addr = {pc[31:2], 2'b00};
  assign misalign  = misalign_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      inst       <= NOP;
      inst_valid <= 1'b0;
      fetch_cnt  <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            fetch_cnt  <= fetch_cnt + 32'd1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (npc_valid) begin
            pc         <= npc;
            inst_valid <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
            if (npc[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
              imem_req   <= 1'b0;
              state      <= FAULT;
            end else begin
              imem_req <= 1'b1;
              state    <= REQ;
            end
`else
            imem_req <= 1'b1;
            state    <= REQ;
`endif
          end
        end
`ifdef PC_MISALIGN_CHK_EN
        FAULT: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
`endif
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: memory responder plus scoreboard of expected {pc, inst, count} per fetch.
module tb_pc_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] npc = 32'd0;
  logic        npc_valid = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] fetch_cnt;
  logic        misalign;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rstn(rstn), .npc(npc), .npc_valid(npc_valid),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .fetch_cnt(fetch_cnt), .misalign(misalign)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        iv_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every new inst_valid presentation must match the oldest expected fetch.
  always @(negedge clk) begin
    if (rstn && inst_valid && !iv_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got inst %h expected no fetch", inst);
      end else begin
        mon_e = sb.pop_front();
        chk("mon_pc", pc, mon_e.pc);
        chk("mon_inst", inst, mon_e.inst);
        chk("mon_cnt", fetch_cnt, mon_e.cnt);
      end
    end
    iv_prev = rstn ? inst_valid : 1'b0;
  end

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Serve one fetch: stall grant, then return data after dly WAIT cycles, then linger in HOLD.
  task automatic fetch_one(input int stall, input int dly, input logic [31:0] data,
                           input bit poke, input int hold);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("req_seen", imem_req, 1'b1);
    if (imem_req !== 1'b1) return;
    chk("req_addr", imem_addr, word_addr(m_pc));
    for (int i = 0; i < stall; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      @(negedge clk);
      chk1("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, word_addr(m_pc));
      chk1("stall_iv", inst_valid, 1'b0);
    end
    imem_gnt    = 1'b1;
    imem_rvalid = 1'($urandom_range(0, 1));
    imem_rdata  = $urandom;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    chk1("wait_req", imem_req, 1'b0);
    for (int i = 0; i < dly; i++) begin
      if (poke) begin
        npc_valid = 1'b1;
        npc       = $urandom;
      end
      @(negedge clk);
      npc_valid = 1'b0;
      chk1("wait_req2", imem_req, 1'b0);
      chk("wait_pc", pc, m_pc);
      chk1("wait_iv", inst_valid, 1'b0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    m_cnt       = m_cnt + 32'd1;
    sb.push_back('{pc: m_pc, inst: data, cnt: m_cnt});
    @(negedge clk);
    imem_rvalid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      @(negedge clk);
      chk1("hold_req", imem_req, 1'b0);
      chk1("hold_iv", inst_valid, 1'b1);
    end
    imem_rvalid = 1'b0;
  endtask

  task automatic retire(input logic [31:0] nv);
    npc       = nv;
    npc_valid = 1'b1;
    @(negedge clk);
    npc_valid = 1'b0;
    npc       = $urandom;
    m_pc      = nv;
    chk("ret_pc", pc, nv);
    chk1("ret_iv", inst_valid, 1'b0);
`ifdef PC_MISALIGN_CHK_EN
    if (nv[1:0] != 2'b00) begin
      chk1("ret_misalign", misalign, 1'b1);
      chk1("ret_fault_req", imem_req, 1'b0);
      return;
    end
`endif
    chk1("ret_req", imem_req, 1'b1);
    chk("ret_addr", imem_addr, word_addr(nv));
    chk1("ret_misalign0", misalign, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nv;
    logic [31:0] frozen;
    m_pc  = RST_PC;
    m_cnt = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_inst", inst, NOP);
    chk1("rst_iv", inst_valid, 1'b0);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk1("rst_misalign", misalign, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    chk1("edge1_req", imem_req, 1'b1);
    chk("edge1_addr", imem_addr, RST_PC);

    fetch_one(4, 0, 32'h0050_0093, 1'b0, 1);
    retire(32'h0000_3010);

    for (int t = 0; t < 40; t++) begin
      fetch_one($urandom_range(0, 4), $urandom_range(0, 3), $urandom,
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
      nv = {16'h0000, 14'($urandom), 2'b00};
`ifndef PC_MISALIGN_CHK_EN
      if ($urandom_range(0, 3) == 0) nv[1:0] = 2'($urandom_range(1, 3));
`endif
      retire(nv);
    end

    fetch_one(1, 1, 32'h0000_0113, 1'b1, 0);
    retire(32'h0000_3010);

    // Reset while a request is outstanding; stale rvalid afterwards must be ignored.
    chk1("pre_rst_req", imem_req, 1'b1);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rstn     = 1'b0;
    @(negedge clk);
    chk1("mid_rst_iv", inst_valid, 1'b0);
    chk1("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_pc", pc, RST_PC);
    sb.delete();
    m_pc  = RST_PC;
    m_cnt = 32'd0;
    rstn        = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("stale_iv", inst_valid, 1'b0);
    chk1("stale_req", imem_req, 1'b1);
    chk("stale_addr", imem_addr, RST_PC);
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk1("stale_iv2", inst_valid, 1'b0);
    chk("stale_inst", inst, NOP);
    chk("stale_cnt", fetch_cnt, 32'd0);

    fetch_one(2, 2, 32'h0010_0073, 1'b0, 1);
`ifdef PC_MISALIGN_CHK_EN
    retire(32'h0000_3012);
    frozen = fetch_cnt;
    for (int i = 0; i < 20; i++) begin
      imem_gnt    = 1'($urandom_range(0, 1));
      imem_rvalid = 1'($urandom_range(0, 1));
      npc_valid   = 1'($urandom_range(0, 1));
      npc         = $urandom;
      @(negedge clk);
      chk1("fault_req", imem_req, 1'b0);
      chk1("fault_iv", inst_valid, 1'b0);
      chk1("fault_misalign", misalign, 1'b1);
      chk("fault_cnt", fetch_cnt, frozen);
      chk("fault_pc", pc, 32'h0000_3012);
    end
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    npc_valid   = 1'b0;
`else
    retire(32'h0000_3012);
    frozen = 32'd0;
    fetch_one(0, 0, 32'h0000_0013, 1'b0, 0);
    retire(32'h0000_3020);
`endif
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
